// File: rtl/ascon_init_ctrl.sv
// ---------------------------------------------------------------------------
// ascon_init_ctrl
// Iterative ASCON initialization sequencer. Loads {iv,k0,k1,n0,n1} into the
// 320-bit state, drives an external combinational single-round permutation
// unit for ROUNDS cycles with the proper round constants, XORs the key into
// the two least-significant words and holds the result until accepted.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      job handshake (iv, k0, k1, n0, n1 sampled on accept)
//   out_valid / out_ready    result handshake, state on s0..s4 (s0 = MSW)
//   busy                     high while rounds are executing
//   rnd_x0..rnd_x4, rnd_rc   state and round constant to the round unit
//   rnd_y0..rnd_y4           round unit result (combinational from rnd_x/rnd_rc)
// ---------------------------------------------------------------------------
module ascon_init_ctrl #(
  parameter int ROUNDS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] iv,
  input  logic [63:0] k0,
  input  logic [63:0] k1,
  input  logic [63:0] n0,
  input  logic [63:0] n1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] s0,
  output logic [63:0] s1,
  output logic [63:0] s2,
  output logic [63:0] s3,
  output logic [63:0] s4,
  output logic        busy,
  output logic [63:0] rnd_x0,
  output logic [63:0] rnd_x1,
  output logic [63:0] rnd_x2,
  output logic [63:0] rnd_x3,
  output logic [63:0] rnd_x4,
  output logic [7:0]  rnd_rc,
  input  logic [63:0] rnd_y0,
  input  logic [63:0] rnd_y1,
  input  logic [63:0] rnd_y2,
  input  logic [63:0] rnd_y3,
  input  logic [63:0] rnd_y4
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A shortened schedule uses the tail of the 12-entry constant table.
  localparam logic [3:0] RC_BASE  = 4'(12 - ROUNDS);
  localparam logic [3:0] CNT_LAST = 4'(ROUNDS - 1);

  logic [1:0]   fsm_q, fsm_d;
  logic [319:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   rc_idx;

  assign rc_idx = cnt_q + RC_BASE;

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    key_d = key_q;
    cnt_d = cnt_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          st_d  = {iv, k0, k1, n0, n1};
          key_d = {k0, k1};
          cnt_d = 4'd0;
          fsm_d = ST_RUN;
        end
      end
      ST_RUN: begin
        st_d  = {rnd_y0, rnd_y1, rnd_y2, rnd_y3, rnd_y4};
        // cnt peaks at ROUNDS (<= 12), so the 4-bit counter never wraps.
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          // Final round: fold the key into S3/S4 on the same edge.
          st_d[127:0] = {rnd_y3, rnd_y4} ^ key_q;
          fsm_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= ST_IDLE;
      st_q  <= '0;
      key_q <= '0;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      key_q <= key_d;
      cnt_q <= cnt_d;
    end
  end

  // Handshake/status outputs decode registered state only.
  assign in_ready  = (fsm_q == ST_IDLE);
  assign busy      = (fsm_q == ST_RUN);
  assign out_valid = (fsm_q == ST_DONE);

  assign {s0, s1, s2, s3, s4}                     = st_q;
  assign {rnd_x0, rnd_x1, rnd_x2, rnd_x3, rnd_x4} = st_q;
  assign rnd_rc = (fsm_q == ST_RUN) ? {~rc_idx, rc_idx} : 8'h00;

endmodule

// File: tb/tb_ascon_init_ctrl.sv
module tb_ascon_init_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_valid6 = 1'b0, out_ready6 = 1'b0;
  logic [63:0] iv = '0, k0 = '0, k1 = '0, n0 = '0, n1 = '0;
  logic        use_real = 1'b0;

  wire          in_ready, out_valid, busy;
  wire  [319:0] s_w, rx_w;
  wire  [7:0]   rc_w;
  logic [319:0] ry_w;

  wire          in_ready6, out_valid6, busy6;
  wire  [319:0] s6_w, rx6_w;
  wire  [7:0]   rc6_w;

  int n_vec = 0;
  int n_err = 0;
  logic [319:0] sb[$];

  logic [7:0] rc_tab [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference ASCON permutation round (constant add, S-box, linear layer).
  function automatic logic [319:0] round_f(input logic [319:0] x, input logic [7:0] rc);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = x;
    x2 = x2 ^ {56'd0, rc};
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Golden p12 (or identity) followed by key XOR into the two low words.
  function automatic logic [319:0] golden(input logic [319:0] st, input logic real_r);
    logic [319:0] s;
    s = st;
    if (real_r)
      for (int r = 0; r < 12; r++) s = round_f(s, rc_tab[r]);
    s[127:64] = s[127:64] ^ st[255:192];
    s[63:0]   = s[63:0]   ^ st[191:128];
    return s;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  always_comb begin
    ry_w = rx_w;
    if (use_real) ry_w = round_f(rx_w, rc_w);
  end

  ascon_init_ctrl #(.ROUNDS(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .iv(iv), .k0(k0), .k1(k1), .n0(n0), .n1(n1),
    .out_valid(out_valid), .out_ready(out_ready),
    .s0(s_w[319:256]), .s1(s_w[255:192]), .s2(s_w[191:128]), .s3(s_w[127:64]), .s4(s_w[63:0]),
    .busy(busy),
    .rnd_x0(rx_w[319:256]), .rnd_x1(rx_w[255:192]), .rnd_x2(rx_w[191:128]),
    .rnd_x3(rx_w[127:64]), .rnd_x4(rx_w[63:0]), .rnd_rc(rc_w),
    .rnd_y0(ry_w[319:256]), .rnd_y1(ry_w[255:192]), .rnd_y2(ry_w[191:128]),
    .rnd_y3(ry_w[127:64]), .rnd_y4(ry_w[63:0])
  );

  ascon_init_ctrl #(.ROUNDS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
    .iv(iv), .k0(k0), .k1(k1), .n0(n0), .n1(n1),
    .out_valid(out_valid6), .out_ready(out_ready6),
    .s0(s6_w[319:256]), .s1(s6_w[255:192]), .s2(s6_w[191:128]), .s3(s6_w[127:64]), .s4(s6_w[63:0]),
    .busy(busy6),
    .rnd_x0(rx6_w[319:256]), .rnd_x1(rx6_w[255:192]), .rnd_x2(rx6_w[191:128]),
    .rnd_x3(rx6_w[127:64]), .rnd_x4(rx6_w[63:0]), .rnd_rc(rc6_w),
    .rnd_y0(rx6_w[319:256]), .rnd_y1(rx6_w[255:192]), .rnd_y2(rx6_w[191:128]),
    .rnd_y3(rx6_w[127:64]), .rnd_y4(rx6_w[63:0])
  );

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One job on the ROUNDS=12 instance; called at a negedge with the DUT idle.
  task automatic job12(input logic [319:0] st, input bit chk_rc, input int hold);
    int k;
    logic [319:0] held;
    chk("in_ready_idle", in_ready, 1);
    {iv, k0, k1, n0, n1} = st;
    in_valid = 1'b1;
    sb.push_back(golden(st, use_real));
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 40) begin
      if (chk_rc) begin
        chk("busy_run", busy, 1);
        if (k <= 12) chk("rc_seq", rc_w, rc_tab[k-1]);
      end
      @(negedge clk);
      k++;
    end
    chk("latency", k, 13);
    chk("busy_done", busy, 0);
    chk("rc_idle", rc_w, 8'h00);
    held = s_w;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else chk("result", s_w, sb.pop_front());
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = (h == 1);
      {iv, k0, k1, n0, n1} = ~st;
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_stable", s_w, held);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_valid_low", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int k, j, got, cyc, last_acc;
    logic any_ov;
    logic [319:0] st;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s", s_w, '0);
    chk("rst_rnd_x", rx_w, '0);
    chk("rst_rc", rc_w, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity stub with constant vector, round-constant monitor
    st = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
          64'h1111111111111111, 64'h2222222222222222};
    job12(st, 1'b1, 0);
    chk("id_s3", s_w[127:64], 64'h1111111111111111 ^ 64'h0001020304050607);
    chk("id_s4", s_w[63:0],   64'h2222222222222222 ^ 64'h08090a0b0c0d0e0f);

    // Backpressure with an ignored in_valid pulse, then a fresh job
    job12({rnd64(), rnd64(), rnd64(), rnd64(), rnd64()}, 1'b0, 5);
    job12({rnd64(), rnd64(), rnd64(), rnd64(), rnd64()}, 1'b0, 0);

    // ROUNDS=6 instance
    {iv, k0, k1, n0, n1} = st;
    in_valid6 = 1'b1;
    @(negedge clk);
    in_valid6 = 1'b0;
    k = 1;
    while (!out_valid6 && k < 40) begin
      chk("r6_busy", busy6, 1);
      if (k <= 6) chk("r6_rc_seq", rc6_w, rc_tab[5+k]);
      @(negedge clk);
      k++;
    end
    chk("r6_latency", k, 7);
    chk("r6_rc_idle", rc6_w, 8'h00);
    chk("r6_result", s6_w, golden(st, 1'b0));
    out_ready6 = 1'b1;
    @(negedge clk);
    out_ready6 = 1'b0;
    chk("r6_hs", out_valid6, 0);

    // Real round function, random vectors
    use_real = 1'b1;
    for (int v = 0; v < 200; v++)
      job12({rnd64(), rnd64(), rnd64(), rnd64(), rnd64()}, 1'b0, 0);

    // Asynchronous reset at RUN cycle 7
    chk("ar_in_ready", in_ready, 1);
    {iv, k0, k1, n0, n1} = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("ar_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_in_ready_rst", in_ready, 1);
    chk("ar_busy_rst", busy, 0);
    chk("ar_valid_rst", out_valid, 0);
    chk("ar_s_rst", s_w, '0);
    chk("ar_x_rst", rx_w, '0);
    chk("ar_rc_rst", rc_w, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    any_ov = 1'b0;
    repeat (15) begin
      @(negedge clk);
      any_ov |= out_valid;
    end
    chk("ar_no_valid", any_ov, 0);
    job12({rnd64(), rnd64(), rnd64(), rnd64(), rnd64()}, 1'b0, 0);

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    j = 0; got = 0; cyc = 0; last_acc = 0;
    while (got < 4 && cyc < 200) begin
      if (out_valid) begin
        if (sb.size() == 0) chk("b2b_extra", 1, 0);
        else chk("b2b_result", s_w, sb.pop_front());
        got++;
      end
      if (in_ready) begin
        if (j < 4) begin
          st = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
          {iv, k0, k1, n0, n1} = st;
          sb.push_back(golden(st, 1'b1));
          in_valid = 1'b1;
          if (j > 0) chk("b2b_spacing", cyc - last_acc, 14);
          last_acc = cyc;
          j++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_count", got, 4);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_init_ctrl.md
# ascon_init_ctrl

Sequencer for the ASCON initialization phase, built around an external single-round permutation unit. It accepts IV, key and nonce, loads the 320-bit state and drives the round unit for ROUNDS consecutive cycles with the correct round constants. It then XORs the key into the two least-significant state words and presents the initialized state downstream. It replaces the fully unrolled p12 initialization, trading latency for area, and feeds associated-data and plaintext processing.

## Interface

Parameters:
- ROUNDS, default 12: number of permutation rounds; legal range 1..12. Round constants start at index 12-ROUNDS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  IV/key/nonce valid
- in_ready  out  1  controller can accept a new job
- iv  in  64  initialization vector
- k0, k1  in  64 each  key, MSW first
- n0, n1  in  64 each  nonce, MSW first
- out_valid  out  1  initialized state available
- out_ready  in  1  downstream accepts state
- s0..s4  out  64 each  state words, s0 = MSW
- busy  out  1  high while rounds are executing
- rnd_x0..rnd_x4  out  64 each  state presented to the round unit
- rnd_rc  out  8  round constant for the current round
- rnd_y0..rnd_y4  in  64 each  round unit result; combinational from rnd_x/rnd_rc

## Operation

- State registers: S[0..4] (320 b), key latch K0/K1, round counter cnt (4 b), FSM {IDLE, RUN, DONE}.
- in_ready = (fsm==IDLE). busy = (fsm==RUN). out_valid = (fsm==DONE). All three are decoded from registered state.
- IDLE, in_valid&&in_ready at the clock edge:
  - S <= {iv,k0,k1,n0,n1}; K <= {k0,k1}; cnt <= 0; fsm <= RUN.
  - in_valid while not IDLE is ignored. Inputs are sampled only at acceptance.
- RUN:
  - rnd_x = S. rnd_rc = {~i[3:0], i[3:0]}, where i = cnt + 12 - ROUNDS (i=0 gives 0xf0, i=11 gives 0x4b).
  - Each edge: S <= rnd_y; cnt <= cnt+1.
  - When cnt==ROUNDS-1, the same edge writes S3 <= rnd_y3^K0, S4 <= rnd_y4^K1, S0..S2 <= rnd_y0..2, and sets fsm <= DONE.
- Outside RUN: rnd_rc = 0x00; rnd_x = S.
- DONE:
  - s0..s4 = S, held stable.
  - On out_valid&&out_ready, fsm <= IDLE. S is retained (not cleared) until the next load.
- s0..s4 always reflect S. They are meaningful only while out_valid.
- The 4-bit cnt must not wrap for any legal ROUNDS.

## Timing

- Reset (async, rst_n low): fsm=IDLE, S=0, K=0, cnt=0. Outputs: in_ready=1, out_valid=0, busy=0, s0..s4=0, rnd_x*=0, rnd_rc=0x00.
- Reset mid-RUN or mid-DONE aborts the job immediately. No partial result is ever flagged valid.
- Acceptance edge E0: busy=1 for cycles E0+1..E0+ROUNDS.
- out_valid rises after edge E0+ROUNDS, i.e. latency = ROUNDS cycles. With ROUNDS=12, out_valid is high 12 cycles after acceptance.
- out_ready may be held high early. The handshake completes on the first cycle of DONE: minimum occupancy is ROUNDS+1 cycles per job.
- in_ready returns one cycle after the output handshake. There is no same-cycle output/input overlap, so back-to-back throughput is one job per ROUNDS+2 cycles.
- out_ready low keeps DONE indefinitely, with s* stable and in_ready=0.
- There is no combinational path from in_valid or out_ready to any output.

## Test plan

- Identity stub round (rnd_y=rnd_x), iv=0x80400c0600000000, k0=0x0001020304050607, k1=0x08090a0b0c0d0e0f, n0=0x1111111111111111, n1=0x2222222222222222:
  - s0..s2 = iv, k0, k1.
  - s3 = n0^k0, s4 = n1^k1.
  - out_valid exactly 12 cycles after acceptance.
- Monitor rnd_rc during RUN, ROUNDS=12: sequence 0xf0,0xe1,0xd2,0xc3,0xb4,0xa5,0x96,0x87,0x78,0x69,0x5a,0x4b, then 0x00. With ROUNDS=6: 0x96..0x4b, and out_valid at 6 cycles.
- Real ascon_round unit, random IV/key/nonce (200 vectors): s0..s4 must equal the golden p12 + key-XOR model.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, s* unchanged, in_ready=0. A pulse of in_valid with different data during this time is ignored; the next accepted job uses the data present when in_ready=1.
- Drop rst_n at RUN cycle 7 → all outputs take reset values asynchronously, no out_valid pulse. The next job after release completes normally.
- Back-to-back jobs with in_valid and out_ready tied high → acceptances spaced 14 cycles apart at ROUNDS=12, each result correct.
